// File: rtl/osd_spi_pkg.sv
// Shared definitions for the OSD SPI command transmitter.
// Op codes, header bytes, FSM state encoding and header builder.
package osd_spi_pkg;

    localparam logic [1:0] OP_DISABLE = 2'd0;
    localparam logic [1:0] OP_ENABLE  = 2'd1;
    localparam logic [1:0] OP_WRITE   = 2'd2;
    localparam logic [1:0] OP_RSVD    = 2'd3;

    localparam logic [7:0] HDR_WRITE  = 8'h20;
    localparam logic [7:0] HDR_ENABLE = 8'h40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_FETCH,
        ST_HOLD,
        ST_GAP
    } state_e;

    function automatic logic [7:0] hdr_byte(
        input logic [1:0] op,
        input logic [2:0] line
    );
        logic [7:0] h;
        h = 8'h00;
        case (op)
            OP_DISABLE: h = HDR_ENABLE;
            OP_ENABLE:  h = HDR_ENABLE | 8'h01;
            OP_WRITE:   h = HDR_WRITE | {5'b0, line};
            default:    h = 8'h00;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/osd_spi_shifter.sv
// Byte serializer: half-period divider, SCK generation, MSB-first shift.
// DO changes only on the cycle SCK falls; bit_done marks the end of bit 0.
module osd_spi_shifter
    import osd_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       run_i,
    input  logic       shift_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       tick_o,
    output logic       bit_done_o,
    output logic       sck_o,
    output logic       do_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_q, div_d;
    logic          sck_q, sck_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sr_q, sr_d;

    assign tick_o     = run_i && (div_q == DIV_LAST);
    assign bit_done_o = shift_i && tick_o && sck_q && (bit_q == 3'd0);
    assign sck_o      = sck_q;
    assign do_o       = sr_q[7];

    always_comb begin
        div_d = '0;
        sck_d = sck_q;
        bit_d = bit_q;
        sr_d  = sr_q;
        if (run_i && !tick_o) begin
            div_d = div_q + 1'b1;
        end
        if (load_i) begin
            sr_d  = data_i;
            bit_d = 3'd7;
            sck_d = 1'b0;
        end else if (shift_i && tick_o) begin
            if (!sck_q) begin
                sck_d = 1'b1;
            end else begin
                // falling edge: present the next bit
                sck_d = 1'b0;
                sr_d  = {sr_q[6:0], 1'b0};
                bit_d = bit_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            sck_q <= 1'b0;
            bit_q <= 3'd7;
            sr_q  <= 8'h00;
        end else begin
            div_q <= div_d;
            sck_q <= sck_d;
            bit_q <= bit_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/osd_spi_tx.sv
// OSD overlay SPI command transmitter (SS3 low, SCK idle low, MSB first).
// Define OSD_SPI_TX_COUNT_EN to enable the tx_bytes counter.
module osd_spi_tx
    import osd_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_line,
    input  logic [7:0]  cmd_len,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        busy,
    output logic        SPI_SCK,
    output logic        SPI_SS3,
    output logic        SPI_DO,
    output logic [15:0] tx_bytes
);

    localparam int unsigned GW = (CS_GAP > 0) ? $clog2(CS_GAP + 1) : 1;

    state_e        state_q;
    logic [8:0]    rem_q;
    logic [GW-1:0] gap_q;
    logic          ss3_q;
    logic          rdy_q;
    logic          busy_q;

    logic       accept;
    logic       tick;
    logic       bit_done;
    logic       load;
    logic       run;
    logic       shift;
    logic [7:0] load_data;

    assign accept     = cmd_valid && rdy_q;
    assign data_ready = (state_q == ST_FETCH);
    assign cmd_ready  = rdy_q;
    assign busy       = busy_q;
    assign SPI_SS3    = ss3_q;

    assign run   = (state_q != ST_IDLE) && (state_q != ST_FETCH);
    assign shift = (state_q == ST_SHIFT);
    assign load  = ((state_q == ST_IDLE) && accept && (cmd_op != OP_RSVD))
                || ((state_q == ST_FETCH) && data_valid);
    assign load_data = (state_q == ST_FETCH) ? data_in
                                             : hdr_byte(cmd_op, cmd_line);

    osd_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .run_i      (run),
        .shift_i    (shift),
        .load_i     (load),
        .data_i     (load_data),
        .tick_o     (tick),
        .bit_done_o (bit_done),
        .sck_o      (SPI_SCK),
        .do_o       (SPI_DO)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            gap_q   <= '0;
            ss3_q   <= 1'b1;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rdy_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (cmd_op == OP_RSVD) begin
                            // dropped: one GAP cycle, no SPI activity
                            state_q <= ST_GAP;
                            gap_q   <= '0;
                        end else begin
                            state_q <= ST_SETUP;
                            ss3_q   <= 1'b0;
                            rem_q   <= (cmd_op == OP_WRITE)
                                     ? ({1'b0, cmd_len} + 9'd1) : 9'd0;
                        end
                    end
                end
                ST_SETUP: begin
                    if (tick) state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_done) begin
                        state_q <= (rem_q != '0) ? ST_FETCH : ST_HOLD;
                    end
                end
                ST_FETCH: begin
                    if (data_valid) begin
                        rem_q   <= rem_q - 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        state_q <= ST_GAP;
                        ss3_q   <= 1'b1;
                        gap_q   <= GW'(CS_GAP);
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (tick) begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef OSD_SPI_TX_COUNT_EN
    logic [15:0] tx_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tx_q <= 16'd0;
        end else if (bit_done) begin
            tx_q <= tx_q + 16'd1;
        end
    end

    assign tx_bytes = tx_q;
`else
    assign tx_bytes = 16'd0;
`endif

endmodule
